// File: rtl/ecpri_pkg.sv
// Shared eCPRI constants, TX state encoding and the RMA response header byte mux.
package ecpri_pkg;

    localparam logic [7:0] ECPRI_REV_BYTE = 8'h10;
    localparam logic [7:0] ECPRI_MSG_RMA  = 8'h04;
    localparam int         RMA_HDR_LEN    = 12;
    localparam int         ECPRI_HDR_LEN  = 4;
    localparam logic [7:0] RMA_RD_RESP    = 8'h01;
    localparam logic [7:0] RMA_WR_RESP    = 8'h11;

    localparam int         RESP_HDR_BYTES = ECPRI_HDR_LEN + RMA_HDR_LEN;
    localparam logic [3:0] HDR_LAST_IDX   = 4'(RESP_HDR_BYTES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2
    } tx_state_e;

    // Byte idx of the 16-byte response header; multi-byte fields are big-endian.
    function automatic logic [7:0] rma_resp_hdr_byte(
        input logic [3:0]  idx,
        input logic        is_read,
        input logic [7:0]  len,
        input logic [7:0]  rma,
        input logic [15:0] elem,
        input logic [47:0] addr
    );
        logic [15:0] psize;
        logic [7:0]  b;
        psize = 16'(RMA_HDR_LEN) + (is_read ? {8'h00, len} : 16'h0000);
        case (idx)
            4'd0:    b = ECPRI_REV_BYTE;
            4'd1:    b = ECPRI_MSG_RMA;
            4'd2:    b = psize[15:8];
            4'd3:    b = psize[7:0];
            4'd4:    b = rma;
            4'd5:    b = is_read ? RMA_RD_RESP : RMA_WR_RESP;
            4'd6:    b = elem[15:8];
            4'd7:    b = elem[7:0];
            4'd8:    b = addr[47:40];
            4'd9:    b = addr[39:32];
            4'd10:   b = addr[31:24];
            4'd11:   b = addr[23:16];
            4'd12:   b = addr[15:8];
            4'd13:   b = addr[7:0];
            4'd14:   b = 8'h00;
            default: b = len;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/ecpri_tx_skid.sv
// Two-entry byte FIFO between the 1-cycle-latency packet memory and the tx handshake.
module ecpri_tx_skid
    import ecpri_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [1:0]       count,
    output logic             empty
);

    logic [WIDTH-1:0] slot_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       cnt_q;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && (cnt_q != 2'd2);
    assign do_pop  = pop && (cnt_q != 2'd0);

    // storage, pointers and occupancy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_q[0] <= '0;
            slot_q[1] <= '0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            cnt_q     <= 2'd0;
        end else begin
            if (do_push) begin
                slot_q[wr_ptr_q] <= push_data;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            cnt_q <= cnt_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    assign head  = slot_q[rd_ptr_q];
    assign count = cnt_q;
    assign empty = (cnt_q == 2'd0);

endmodule

// File: rtl/ecpri_resp_tx.sv
// eCPRI RMA response builder: header mux, memory prefetch and one pending request slot.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  IDLE    | nothing to send, pending slot empty
//  HDR     | streaming header bytes B0..B15; read data prefetch running
//  DATA    | streaming read data bytes out of the skid FIFO
module ecpri_resp_tx
    import ecpri_pkg::*;
#(
    parameter int          DATA_WIDTH = 8,
    parameter int          ADDR_WIDTH = 16,
    parameter logic [15:0] ELEMENT_ID = 16'h0000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  send_read_resp,
    input  logic                  send_write_resp,
    input  logic [7:0]            resp_payload_len,
    input  logic [ADDR_WIDTH-1:0] resp_addr,
    input  logic [7:0]            rma_id,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_oe,
    input  logic [DATA_WIDTH-1:0] mem_data,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_valid,
    output logic                  tx_last,
    input  logic                  tx_ready,
    output logic                  busy,
    output logic                  err_drop
);

    tx_state_e             state_q, state_d;

    logic                  cur_rd_q;
    logic [7:0]            cur_len_q;
    logic [ADDR_WIDTH-1:0] cur_addr_q;
    logic [7:0]            cur_rma_q;

    logic                  pend_valid_q;
    logic                  pend_rd_q;
    logic [7:0]            pend_len_q;
    logic [ADDR_WIDTH-1:0] pend_addr_q;
    logic [7:0]            pend_rma_q;

    logic [3:0]            hdr_cnt_q;
    logic [7:0]            data_cnt_q;
    logic [8:0]            fetch_cnt_q;
    logic                  oe_q;
    logic                  err_drop_q;

    logic                  any_req;
    logic                  has_data;
    logic                  start;
    logic                  finish;
    logic                  fifo_pop;
    logic                  cur_from_pend;
    logic                  load_rd;
    logic                  pend_load;
    logic                  pend_load_rd;
    logic                  drop;
    logic                  fetch_room;

    logic [DATA_WIDTH-1:0] fifo_head;
    logic [1:0]            fifo_cnt;
    logic                  fifo_empty;

    assign any_req  = send_read_resp || send_write_resp;
    assign has_data = cur_rd_q && (cur_len_q != 8'd0);

    ecpri_tx_skid #(.WIDTH(DATA_WIDTH)) u_skid (
        .clk       (clk),
        .reset     (reset),
        .push      (oe_q),
        .push_data (mem_data),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .count     (fifo_cnt),
        .empty     (fifo_empty)
    );

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next state, stream outputs and start/finish strobes
    always_comb begin
        state_d  = state_q;
        tx_valid = 1'b0;
        tx_data  = '0;
        tx_last  = 1'b0;
        fifo_pop = 1'b0;
        start    = 1'b0;
        finish   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (any_req || pend_valid_q) begin
                    start = 1'b1;
                end
            end
            ST_HDR: begin
                tx_valid = 1'b1;
                tx_data  = rma_resp_hdr_byte(hdr_cnt_q, cur_rd_q, cur_len_q, cur_rma_q,
                                             ELEMENT_ID, 48'(cur_addr_q));
                tx_last  = (hdr_cnt_q == HDR_LAST_IDX) && !has_data;
                if (tx_ready && (hdr_cnt_q == HDR_LAST_IDX)) begin
                    if (has_data) begin
                        state_d = ST_DATA;
                    end else begin
                        finish = 1'b1;
                    end
                end
            end
            ST_DATA: begin
                tx_valid = !fifo_empty;
                tx_data  = fifo_head;
                tx_last  = (data_cnt_q == (cur_len_q - 8'd1));
                fifo_pop = tx_valid && tx_ready;
                if (fifo_pop && tx_last) begin
                    finish = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // back-to-back: the next response starts the cycle after tx_last transfers
        if (finish) begin
            if (pend_valid_q || any_req) begin
                start = 1'b1;
            end else begin
                state_d = ST_IDLE;
            end
        end
        if (start) begin
            state_d = ST_HDR;
        end
    end

    // route incoming requests to the current slot, the pending slot, or drop them
    always_comb begin
        cur_from_pend = start && pend_valid_q;
        load_rd       = cur_from_pend ? pend_rd_q : send_read_resp;
        pend_load     = 1'b0;
        pend_load_rd  = 1'b0;
        drop          = 1'b0;
        if (start && !pend_valid_q) begin
            // read wins the current slot; a simultaneous write waits
            pend_load    = send_read_resp && send_write_resp;
            pend_load_rd = 1'b0;
        end else begin
            pend_load_rd = send_read_resp;
            if (any_req) begin
                if (!pend_valid_q || start) begin
                    pend_load = 1'b1;
                end else begin
                    drop = 1'b1;
                end
            end
            if (send_read_resp && send_write_resp) begin
                drop = 1'b1;
            end
        end
    end

    // current response fields, loaded at start
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_rd_q   <= 1'b0;
            cur_len_q  <= 8'd0;
            cur_addr_q <= '0;
            cur_rma_q  <= 8'd0;
        end else if (start) begin
            cur_rd_q   <= load_rd;
            cur_len_q  <= cur_from_pend ? pend_len_q  : resp_payload_len;
            cur_addr_q <= cur_from_pend ? pend_addr_q : resp_addr;
            cur_rma_q  <= cur_from_pend ? pend_rma_q  : rma_id;
        end
    end

    // single pending request slot
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_valid_q <= 1'b0;
            pend_rd_q    <= 1'b0;
            pend_len_q   <= 8'd0;
            pend_addr_q  <= '0;
            pend_rma_q   <= 8'd0;
        end else if (pend_load) begin
            pend_valid_q <= 1'b1;
            pend_rd_q    <= pend_load_rd;
            pend_len_q   <= resp_payload_len;
            pend_addr_q  <= resp_addr;
            pend_rma_q   <= rma_id;
        end else if (cur_from_pend) begin
            pend_valid_q <= 1'b0;
        end
    end

    // header/data byte counters and memory fetch counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hdr_cnt_q   <= 4'd0;
            data_cnt_q  <= 8'd0;
            fetch_cnt_q <= 9'd0;
        end else if (start) begin
            hdr_cnt_q   <= 4'd0;
            data_cnt_q  <= 8'd0;
            fetch_cnt_q <= 9'd0;
        end else begin
            if ((state_q == ST_HDR) && tx_ready) begin
                hdr_cnt_q <= hdr_cnt_q + 4'd1;
            end
            if (fifo_pop) begin
                data_cnt_q <= data_cnt_q + 8'd1;
            end
            if (mem_oe) begin
                fetch_cnt_q <= fetch_cnt_q + 9'd1;
            end
        end
    end

    // Prefetch starts during the header so data follows B15 without a bubble.
    // Room counts the byte still in flight from the memory.
    assign fetch_room = ({1'b0, fifo_cnt} + {2'b00, oe_q} - {2'b00, fifo_pop}) < 3'd2;
    assign mem_oe     = (state_q != ST_IDLE) && cur_rd_q
                        && (fetch_cnt_q < {1'b0, cur_len_q}) && fetch_room;
    assign mem_addr   = cur_addr_q + ADDR_WIDTH'(fetch_cnt_q);

    // read-data return flag and drop pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            oe_q       <= 1'b0;
            err_drop_q <= 1'b0;
        end else begin
            oe_q       <= mem_oe;
            err_drop_q <= drop;
        end
    end

    assign err_drop = err_drop_q;
    assign busy     = (state_q != ST_IDLE) || pend_valid_q;

endmodule
